// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM duty-cycle front-end controller.
package pwm_ctrl_pkg;

    // Widest duty word supported by the shared saturation helpers.
    localparam int unsigned DUTY_W_MAX = 16;

    typedef logic [DUTY_W_MAX-1:0] duty_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } press_state_e;

    // Step up by one LSB, holding at max_v instead of wrapping.
    function automatic duty_t sat_inc(input duty_t v, input duty_t max_v);
        return (v >= max_v) ? max_v : v + duty_t'(1);
    endfunction

    // Step down by one LSB, holding at zero instead of wrapping.
    function automatic duty_t sat_dec(input duty_t v);
        return (v == '0) ? '0 : v - duty_t'(1);
    endfunction

endpackage

// File: rtl/pwm_btn_press.sv
// One push-button channel: 2-flop synchroniser, debounce filter and
// press/auto-repeat FSM producing single-cycle step pulses.
module pwm_btn_press
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC     = 200,
    parameter int unsigned RPT_DLY_CYC = 5000,
    parameter int unsigned RPT_CYC     = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic step
);

    localparam int unsigned DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned HLD_MAX = (RPT_DLY_CYC > RPT_CYC) ? RPT_DLY_CYC : RPT_CYC;
    localparam int unsigned HLD_W   = (HLD_MAX > 1) ? $clog2(HLD_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [HLD_W-1:0] DLY_LAST = HLD_W'(RPT_DLY_CYC - 1);
    localparam logic [HLD_W-1:0] RPT_LAST = HLD_W'(RPT_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    press_state_e     state_q, state_d;
    logic [HLD_W-1:0] hld_cnt_q, hld_cnt_d;
    logic             step_q, step_d;

    // Synchronise the raw level and accept a change only after it is stable.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Press FSM: first step on press, then delayed auto-repeat while held.
    always_comb begin
        state_d   = state_q;
        hld_cnt_d = hld_cnt_q;
        step_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb_q) begin
                    state_d   = HOLD;
                    step_d    = 1'b1;
                    hld_cnt_d = '0;
                end
            end
            HOLD: begin
                if (!deb_q) begin
                    state_d   = IDLE;
                    hld_cnt_d = '0;
                end else if (hld_cnt_q == DLY_LAST) begin
                    state_d   = REPEAT;
                    step_d    = 1'b1;
                    hld_cnt_d = '0;
                end else begin
                    hld_cnt_d = hld_cnt_q + HLD_W'(1);
                end
            end
            REPEAT: begin
                if (!deb_q) begin
                    state_d   = IDLE;
                    hld_cnt_d = '0;
                end else if (hld_cnt_q == RPT_LAST) begin
                    step_d    = 1'b1;
                    hld_cnt_d = '0;
                end else begin
                    hld_cnt_d = hld_cnt_q + HLD_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                hld_cnt_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            state_q   <= IDLE;
            hld_cnt_q <= '0;
            step_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            state_q   <= state_d;
            hld_cnt_q <= hld_cnt_d;
            step_q    <= step_d;
        end
    end

    assign level = deb_q;
    assign step  = step_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// PWM front-end controller: two debounced buttons step a saturating duty
// word; also drives button LEDs and a 1 Hz square wave / tick.
// Optional SOFT_RAMP_EN: buttons step a target and duty slews 1 LSB per tick.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 10000,
    parameter int unsigned DUTY_W      = 4,
    parameter int unsigned DUTY_RST    = 8,
    parameter int unsigned DEB_CYC     = 200,
    parameter int unsigned RPT_DLY_CYC = 5000,
    parameter int unsigned RPT_CYC     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_incr,
    input  logic              btn_decr,
    output logic [DUTY_W-1:0] duty,
    output logic              inc_led,
    output logic              dec_led,
    output logic              at_max,
    output logic              at_min,
    output logic              clk_1hz,
    output logic              tick_1hz
);

    localparam logic [DUTY_W-1:0] DUTY_TOP  = '1;
    localparam duty_t             DUTY_MAX  = duty_t'(DUTY_TOP);
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(DUTY_RST);
    localparam int unsigned       HALF      = CLK_HZ / 2;
    localparam int unsigned       DIV_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF - 1);

    logic              inc_step, dec_step;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] base_val, stepped_val;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              clk_1hz_q, clk_1hz_d;
    logic              tick_q, tick_d;

    pwm_btn_press #(
        .DEB_CYC     (DEB_CYC),
        .RPT_DLY_CYC (RPT_DLY_CYC),
        .RPT_CYC     (RPT_CYC)
    ) u_inc (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_incr),
        .level   (inc_led),
        .step    (inc_step)
    );

    pwm_btn_press #(
        .DEB_CYC     (DEB_CYC),
        .RPT_DLY_CYC (RPT_DLY_CYC),
        .RPT_CYC     (RPT_CYC)
    ) u_dec (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_decr),
        .level   (dec_led),
        .step    (dec_step)
    );

    // Apply one saturating step; coincident inc and dec cancel.
    always_comb begin
        stepped_val = base_val;
        if (inc_step && !dec_step) begin
            stepped_val = DUTY_W'(sat_inc(duty_t'(base_val), DUTY_MAX));
        end else if (dec_step && !inc_step) begin
            stepped_val = DUTY_W'(sat_dec(duty_t'(base_val)));
        end
    end

`ifdef SOFT_RAMP_EN
    logic [DUTY_W-1:0] target_q, target_d;

    assign base_val = target_q;

    // Steps land in the target; duty walks toward it once per 1 Hz tick.
    always_comb begin
        target_d = stepped_val;
        duty_d   = duty_q;
        if (tick_q) begin
            if (duty_q < target_q) begin
                duty_d = duty_q + DUTY_W'(1);
            end else if (duty_q > target_q) begin
                duty_d = duty_q - DUTY_W'(1);
            end
        end
    end

    // Target register.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= DUTY_INIT;
        end else begin
            target_q <= target_d;
        end
    end

    assign at_max = (target_q == DUTY_TOP);
    assign at_min = (target_q == '0);
`else
    assign base_val = duty_q;

    // Steps go straight into the duty register.
    always_comb begin
        duty_d = stepped_val;
    end

    assign at_max = (duty_q == DUTY_TOP);
    assign at_min = (duty_q == '0);
`endif

    // Half-period counter; tick fires on the low-to-high toggle.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        clk_1hz_d = clk_1hz_q;
        tick_d    = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            clk_1hz_d = ~clk_1hz_q;
            tick_d    = ~clk_1hz_q;
        end
    end

    // Duty and divider registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q    <= DUTY_INIT;
            div_cnt_q <= '0;
            clk_1hz_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            duty_q    <= duty_d;
            div_cnt_q <= div_cnt_d;
            clk_1hz_q <= clk_1hz_d;
            tick_q    <= tick_d;
        end
    end

    assign duty     = duty_q;
    assign clk_1hz  = clk_1hz_q;
    assign tick_1hz = tick_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: stimulus pushes timed expectations,
// a monitor pops and compares them one step after each rising edge.
module tb_pwm_duty_ctrl;

    localparam int unsigned CLK_HZ = 20;
    localparam int unsigned DUTY_W = 4;

    localparam int S_DUTY = 0;
    localparam int S_INC  = 1;
    localparam int S_DEC  = 2;
    localparam int S_MAX  = 3;
    localparam int S_MIN  = 4;
    localparam int S_CLK  = 5;
    localparam int S_TICK = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn_incr;
    logic              btn_decr;
    logic [DUTY_W-1:0] duty;
    logic              inc_led, dec_led, at_max, at_min, clk_1hz, tick_1hz;

    typedef struct {
        int unsigned cyc;
        int          sel;
        int          val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    pwm_duty_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .DUTY_W      (DUTY_W),
        .DUTY_RST    (8),
        .DEB_CYC     (4),
        .RPT_DLY_CYC (20),
        .RPT_CYC     (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_incr (btn_incr),
        .btn_decr (btn_decr),
        .duty     (duty),
        .inc_led  (inc_led),
        .dec_led  (dec_led),
        .at_max   (at_max),
        .at_min   (at_min),
        .clk_1hz  (clk_1hz),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int probe(input int sel);
        case (sel)
            S_DUTY:  return int'(duty);
            S_INC:   return int'(inc_led);
            S_DEC:   return int'(dec_led);
            S_MAX:   return int'(at_max);
            S_MIN:   return int'(at_min);
            S_CLK:   return int'(clk_1hz);
            default: return int'(tick_1hz);
        endcase
    endfunction

    task automatic expect_at(input int unsigned c, input int sel, input int val, input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle reset pulse; checks every output at the reset edge.
    task automatic do_reset();
        int unsigned er;
        @(negedge clk);
        reset = 1'b1;
        er = cyc + 1;
        expect_at(er, S_DUTY, 8, "rst_duty");
        expect_at(er, S_INC,  0, "rst_inc_led");
        expect_at(er, S_DEC,  0, "rst_dec_led");
        expect_at(er, S_MAX,  0, "rst_at_max");
        expect_at(er, S_MIN,  0, "rst_at_min");
        expect_at(er, S_CLK,  0, "rst_clk_1hz");
        expect_at(er, S_TICK, 0, "rst_tick");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare every expectation that has come due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check(e.tag, probe(e.sel), e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired with %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c, r, er;
        reset    = 1'b1;
        btn_incr = 1'b0;
        btn_decr = 1'b0;
        tick_n(3);
        do_reset();

        // Clean 10-cycle increment press: one step, LED follows debounced level.
        c = cyc;
        btn_incr = 1'b1;
        expect_at(c + 5, S_INC,  0, "t1_led_early");
        expect_at(c + 6, S_INC,  1, "t1_led_on");
        expect_at(c + 7, S_DUTY, 8, "t1_duty_before");
        expect_at(c + 8, S_DUTY, 9, "t1_duty_step");
        tick_n(10);
        r = cyc;
        btn_incr = 1'b0;
        expect_at(r + 5,  S_INC,  1, "t1_led_hold");
        expect_at(r + 6,  S_INC,  0, "t1_led_off");
        expect_at(r + 25, S_DUTY, 9, "t1_no_more_step");
        tick_n(30);

        // 3-cycle glitches on decrement never get through the debouncer.
        c = cyc;
        expect_at(c + 10, S_DEC,  0, "t2_dec_led_a");
        expect_at(c + 30, S_DEC,  0, "t2_dec_led_b");
        expect_at(c + 62, S_DEC,  0, "t2_dec_led_c");
        expect_at(c + 62, S_DUTY, 9, "t2_duty");
        for (int i = 0; i < 10; i++) begin
            btn_decr = 1'b1;
            tick_n(3);
            btn_decr = 1'b0;
            tick_n(3);
        end
        tick_n(5);

        // Held increment from 8: first step, +20 delay, then every 5; saturates at 15.
        do_reset();
        c = cyc;
        btn_incr = 1'b1;
        expect_at(c + 7,  S_DUTY, 8,  "t3_before");
        expect_at(c + 8,  S_DUTY, 9,  "t3_first");
        expect_at(c + 27, S_DUTY, 9,  "t3_delay_hold");
        expect_at(c + 28, S_DUTY, 10, "t3_rpt_start");
        expect_at(c + 32, S_DUTY, 10, "t3_rpt_gap");
        expect_at(c + 33, S_DUTY, 11, "t3_rpt2");
        expect_at(c + 38, S_DUTY, 12, "t3_rpt3");
        expect_at(c + 52, S_DUTY, 14, "t3_pre_max");
        expect_at(c + 52, S_MAX,  0,  "t3_at_max_low");
        expect_at(c + 53, S_DUTY, 15, "t3_max");
        expect_at(c + 53, S_MAX,  1,  "t3_at_max");
        expect_at(c + 58, S_DUTY, 15, "t3_sat");
        tick_n(60);
        r = cyc;
        btn_incr = 1'b0;
        expect_at(r + 10, S_DUTY, 15, "t3_no_wrap");
        expect_at(r + 10, S_MAX,  1,  "t3_at_max_end");
        expect_at(r + 10, S_MIN,  0,  "t3_at_min_end");
        tick_n(12);

        // Held decrement from 15 down through 1 to a saturated 0.
        c = cyc;
        btn_decr = 1'b1;
        expect_at(c + 8,  S_DUTY, 14, "t4_first");
        expect_at(c + 28, S_DUTY, 13, "t4_rpt_start");
        expect_at(c + 88, S_DUTY, 1,  "t4_one");
        expect_at(c + 88, S_MIN,  0,  "t4_at_min_low");
        expect_at(c + 93, S_DUTY, 0,  "t4_zero");
        expect_at(c + 93, S_MIN,  1,  "t4_at_min");
        expect_at(c + 118, S_DUTY, 0, "t4_sat");
        tick_n(120);
        r = cyc;
        btn_decr = 1'b0;
        expect_at(r + 10, S_DUTY, 0, "t4_no_wrap");
        expect_at(r + 10, S_MIN,  1, "t4_at_min_end");
        expect_at(r + 10, S_DEC,  0, "t4_dec_led_off");
        tick_n(12);

        // Both buttons with identical timing: every step pair cancels.
        do_reset();
        c = cyc;
        btn_incr = 1'b1;
        btn_decr = 1'b1;
        expect_at(c + 5,  S_INC,  0, "t5_inc_early");
        expect_at(c + 5,  S_DEC,  0, "t5_dec_early");
        expect_at(c + 6,  S_INC,  1, "t5_inc_led");
        expect_at(c + 6,  S_DEC,  1, "t5_dec_led");
        expect_at(c + 8,  S_DUTY, 8, "t5_first");
        expect_at(c + 28, S_DUTY, 8, "t5_rpt");
        expect_at(c + 33, S_DUTY, 8, "t5_rpt2");
        expect_at(c + 44, S_DUTY, 8, "t5_late");
        tick_n(45);
        r = cyc;
        btn_incr = 1'b0;
        btn_decr = 1'b0;
        expect_at(r + 6,  S_INC,  0, "t5_inc_off");
        expect_at(r + 6,  S_DEC,  0, "t5_dec_off");
        expect_at(r + 10, S_DUTY, 8, "t5_end");
        tick_n(12);

        // 1 Hz divider: period 20, high 10, one tick per rising transition.
        do_reset();
        er = cyc;
        for (int k = 1; k <= 100; k++) begin
            expect_at(er + k, S_CLK,  (k / 10) % 2,             "t6_clk_1hz");
            expect_at(er + k, S_TICK, ((k % 20) == 10) ? 1 : 0, "t6_tick");
        end
        tick_n(101);

        // Reset during HOLD, button kept down: re-debounce then exactly one step.
        c = cyc;
        btn_incr = 1'b1;
        expect_at(c + 8, S_DUTY, 9, "t7_step");
        tick_n(15);
        reset = 1'b1;
        expect_at(cyc + 1, S_DUTY, 8, "t7_rst_duty");
        expect_at(cyc + 1, S_INC,  0, "t7_rst_led");
        expect_at(cyc + 1, S_CLK,  0, "t7_rst_clk");
        tick_n(1);
        reset = 1'b0;
        r = cyc;
        expect_at(r + 5,  S_INC,  0, "t7_led_early");
        expect_at(r + 6,  S_INC,  1, "t7_led_on");
        expect_at(r + 7,  S_DUTY, 8, "t7_before");
        expect_at(r + 8,  S_DUTY, 9, "t7_new_step");
        tick_n(20);
        btn_incr = 1'b0;
        expect_at(r + 32, S_DUTY, 9, "t7_single_step");
        tick_n(20);

        check("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
